// File: rtl/oc8051_rom_arb_pkg.sv
// Shared types for the program-memory arbiter: FSM states, requester ids
// and the internal-ROM address decode.
package oc8051_rom_arb_pkg;

    typedef enum logic [2:0] {
        RA_IDLE     = 3'd0,
        RA_INT_WAIT = 3'd1,
        RA_INT_DONE = 3'd2,
        RA_EXT_RD   = 3'd3,
        RA_DONE     = 3'd4
    } ra_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_MOVC  = 1'b1
    } req_id_e;

    localparam logic [1:0] FETCH_LAST_IDX = 2'd2;
    localparam logic [1:0] MOVC_LAST_IDX  = 2'd0;

    // A fetch is internal only if all three bytes fit in the window, so the
    // ROM's 3-byte port never has to wrap.
    function automatic logic int_hit(logic [15:0] a, req_id_e who, int wid);
        logic [31:0] a32;
        a32 = {16'd0, a};
        if (who == REQ_MOVC)
            return (a32 >> wid) == 32'd0;
        return a32 <= ((32'd1 << wid) - 32'd3);
    endfunction

endpackage

// File: rtl/oc8051_rom_arb_if.sv
// CPU, internal ROM and external code-bus signals of the program-memory arbiter.
interface oc8051_rom_arb_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [23:0] fetch_data;
    logic        movc_req;
    logic [15:0] movc_addr;
    logic        movc_ack;
    logic [7:0]  movc_data;
    logic        err;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data1;
    logic [7:0]  rom_data2;
    logic [7:0]  rom_data3;
    logic [15:0] ext_addr;
    logic        ext_stb;
    logic        ext_ack;
    logic [7:0]  ext_data;

    modport master (
        output fetch_req, fetch_addr, movc_req, movc_addr,
               rom_data1, rom_data2, rom_data3, ext_ack, ext_data,
        input  fetch_ack, fetch_data, movc_ack, movc_data, err,
               rom_addr, ext_addr, ext_stb
    );

    modport slave (
        input  fetch_req, fetch_addr, movc_req, movc_addr,
               rom_data1, rom_data2, rom_data3, ext_ack, ext_data,
        output fetch_ack, fetch_data, movc_ack, movc_data, err,
               rom_addr, ext_addr, ext_stb
    );
endinterface

// File: rtl/oc8051_rom_ext_seq.sv
// External code-bus byte sequencer: strobes addr+idx for idx 0..last,
// gaps one cycle between strobes, and aborts on per-byte timeout.
module oc8051_rom_ext_seq
    import oc8051_rom_arb_pkg::*;
#(
    parameter int EXT_TMO = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [1:0]  last,
    output logic        done,
    output logic        err,
    output logic [23:0] data,
    output logic [15:0] ext_addr,
    output logic        ext_stb,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data
);
    localparam logic [7:0] TMO_LAST = 8'(EXT_TMO - 1);

    logic [15:0] base;
    logic [1:0]  idx;
    logic [1:0]  last_q;
    logic [7:0]  tmo;
    logic        busy;

    assign ext_addr = base + {14'd0, idx};

    always_ff @(posedge clk) begin
        if (!rst) begin
            base    <= '0;
            idx     <= '0;
            last_q  <= '0;
            tmo     <= '0;
            busy    <= 1'b0;
            ext_stb <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            data    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                base    <= addr;
                last_q  <= last;
                idx     <= '0;
                tmo     <= '0;
                busy    <= 1'b1;
                ext_stb <= 1'b1;
                err     <= 1'b0;
                data    <= '0;
            end else if (busy) begin
                if (!ext_stb) begin
                    ext_stb <= 1'b1;
                end else if (ext_ack) begin
                    data[{idx, 3'b000} +: 8] <= ext_data;
                    tmo     <= '0;
                    ext_stb <= 1'b0;
                    if (idx == last_q) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end else if (tmo == TMO_LAST) begin
                    // this cycle is the EXT_TMO-th unacked one
                    tmo     <= tmo + 8'd1;
                    ext_stb <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    err     <= 1'b1;
                end else begin
                    tmo <= tmo + 8'd1;
                end
            end
        end
    end
endmodule

// File: rtl/oc8051_rom_arb.sv
// Program-memory arbiter: round-robin between fetch and MOVC, routes each
// access to the registered internal ROM or the external byte sequencer.
module oc8051_rom_arb
    import oc8051_rom_arb_pkg::*;
#(
    parameter int INT_ROM_WID = 7,
    parameter int EXT_TMO     = 255
) (
    input  logic              clk,
    input  logic              rst,
    oc8051_rom_arb_if.slave   bus
);
    ra_state_e   state;
    req_id_e     rr, who, gwho;
    logic [15:0] addr_q, gaddr;
    logic        grant_f, grant_m, ack_busy;
    logic        seq_start, seq_done, seq_err;
    logic [23:0] seq_data, fin_data;
    logic        fin, fin_err;

    assign ack_busy = bus.fetch_ack | bus.movc_ack;

    // No grant while an ack is out: the requester still holds req that cycle.
    always_comb begin
        grant_f = 1'b0;
        grant_m = 1'b0;
        if (state == RA_IDLE && !ack_busy) begin
            if (bus.fetch_req && bus.movc_req) begin
                grant_f = (rr == REQ_FETCH);
                grant_m = (rr == REQ_MOVC);
            end else begin
                grant_f = bus.fetch_req;
                grant_m = bus.movc_req;
            end
        end
        gwho  = grant_m ? REQ_MOVC : REQ_FETCH;
        gaddr = grant_m ? bus.movc_addr : bus.fetch_addr;
    end

    always_comb begin
        fin      = (state == RA_INT_DONE) || (state == RA_DONE);
        fin_err  = (state == RA_DONE) && seq_err;
        fin_data = '0;
        if (state == RA_INT_DONE)
            fin_data = {bus.rom_data3, bus.rom_data2, bus.rom_data1};
        else if (!seq_err)
            fin_data = seq_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RA_IDLE;
            rr             <= REQ_FETCH;
            who            <= REQ_FETCH;
            addr_q         <= '0;
            seq_start      <= 1'b0;
            bus.rom_addr   <= '0;
            bus.fetch_ack  <= 1'b0;
            bus.fetch_data <= '0;
            bus.movc_ack   <= 1'b0;
            bus.movc_data  <= '0;
            bus.err        <= 1'b0;
        end else begin
            bus.fetch_ack <= 1'b0;
            bus.movc_ack  <= 1'b0;
            bus.err       <= 1'b0;
            seq_start     <= 1'b0;
            if (fin) begin
                bus.err <= fin_err;
                if (who == REQ_FETCH) begin
                    bus.fetch_ack  <= 1'b1;
                    bus.fetch_data <= fin_data;
                end else begin
                    bus.movc_ack  <= 1'b1;
                    bus.movc_data <= fin_data[7:0];
                end
            end
            case (state)
                RA_IDLE: if (grant_f || grant_m) begin
                    who    <= gwho;
                    rr     <= grant_m ? REQ_FETCH : REQ_MOVC;
                    addr_q <= gaddr;
                    if (int_hit(gaddr, gwho, INT_ROM_WID)) begin
                        bus.rom_addr <= gaddr;
                        state        <= RA_INT_WAIT;
                    end else begin
                        seq_start <= 1'b1;
                        state     <= RA_EXT_RD;
                    end
                end
                RA_INT_WAIT: state <= RA_INT_DONE;
                RA_INT_DONE: state <= RA_IDLE;
                RA_EXT_RD:   if (seq_done) state <= RA_DONE;
                RA_DONE:     state <= RA_IDLE;
                default:     state <= RA_IDLE;
            endcase
        end
    end

    oc8051_rom_ext_seq #(.EXT_TMO(EXT_TMO)) u_ext_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (seq_start),
        .addr     (addr_q),
        .last     ((who == REQ_MOVC) ? MOVC_LAST_IDX : FETCH_LAST_IDX),
        .done     (seq_done),
        .err      (seq_err),
        .data     (seq_data),
        .ext_addr (bus.ext_addr),
        .ext_stb  (bus.ext_stb),
        .ext_ack  (bus.ext_ack),
        .ext_data (bus.ext_data)
    );
endmodule
